// File: rtl/instr_issue_ctrl.sv
// instr_issue_ctrl
//   Fetch/decode/issue controller for the regfile+ALU datapath. Fetches
//   16-bit instruction words over a request/valid memory interface, decodes
//   them into datapath fields and issues each with a valid/ready handshake.
//   A HALT word parks the controller until run is dropped.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   run               level: 1 = execute, 0 = stop after current instruction
//   mem_addr          fetch address (always equals pc)
//   mem_rd_en         1-cycle read request
//   mem_rdata/rvalid  instruction word and its valid strobe
//   opcode/rdest/rsrc/immediate/useImmediate   decoded datapath fields
//   issue_valid       decoded fields valid; dp_ready accepts them
//   halted            1 while parked on a HALT word
//   pc                current program counter
//   instr_count       instructions issued since reset (wraps)
module instr_issue_ctrl #(
  parameter int unsigned          ADDR_W     = 10,
  parameter logic [ADDR_W-1:0]    START_ADDR = '0,
  parameter logic [15:0]          ZEXT_MASK  = 16'h0,
  parameter logic [3:0]           HALT_OP    = 4'hF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic [3:0]        opcode,
  output logic [3:0]        rdest,
  output logic [3:0]        rsrc,
  output logic [15:0]       immediate,
  output logic              useImmediate,
  output logic              issue_valid,
  input  logic              dp_ready,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       instr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_HALT
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_count;
  logic              r_rd_en;
  logic [3:0]        r_opcode;
  logic [3:0]        r_rdest;
  logic [3:0]        r_rsrc;
  logic [15:0]       r_imm;
  logic              r_use_imm;
  logic              r_issue_valid;
  logic              r_halted;

  logic [3:0]        w_top;
  logic [15:0]       w_imm_ext;

  assign w_top     = mem_rdata[15:12];
  assign w_imm_ext = ZEXT_MASK[w_top] ? {8'h00, mem_rdata[7:0]}
                                      : {{8{mem_rdata[7]}}, mem_rdata[7:0]};

  // The decoded field registers double as the instruction register: they are
  // loaded only when the word is captured, so they stay stable through ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_pc          <= START_ADDR;
      r_count       <= '0;
      r_rd_en       <= 1'b0;
      r_opcode      <= '0;
      r_rdest       <= '0;
      r_rsrc        <= '0;
      r_imm         <= '0;
      r_use_imm     <= 1'b0;
      r_issue_valid <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (run) begin
            r_state <= S_FETCH;
            r_rd_en <= 1'b1;
          end
        end
        S_FETCH: begin
          r_rd_en <= 1'b0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            if (w_top == 4'h0) begin
              r_opcode      <= mem_rdata[7:4];
              r_rdest       <= mem_rdata[11:8];
              r_rsrc        <= mem_rdata[3:0];
              r_imm         <= '0;
              r_use_imm     <= 1'b0;
              r_issue_valid <= 1'b1;
              r_state       <= S_ISSUE;
            end else if (w_top == HALT_OP) begin
              r_halted <= 1'b1;
              r_state  <= S_HALT;
            end else begin
              r_opcode      <= w_top;
              r_rdest       <= mem_rdata[11:8];
              r_rsrc        <= '0;
              r_imm         <= w_imm_ext;
              r_use_imm     <= 1'b1;
              r_issue_valid <= 1'b1;
              r_state       <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (dp_ready) begin
            r_issue_valid <= 1'b0;
            r_pc          <= r_pc + 1'b1;
            r_count       <= r_count + 16'd1;
            // run is sampled only at handshake, so a falling run never drops
            // or repeats the instruction in flight.
            if (run) begin
              r_state <= S_FETCH;
              r_rd_en <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_HALT: begin
          if (!run) begin
            r_halted <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_addr     = r_pc;
  assign mem_rd_en    = r_rd_en;
  assign opcode       = r_opcode;
  assign rdest        = r_rdest;
  assign rsrc         = r_rsrc;
  assign immediate    = r_imm;
  assign useImmediate = r_use_imm;
  assign issue_valid  = r_issue_valid;
  assign halted       = r_halted;
  assign pc           = r_pc;
  assign instr_count  = r_count;

endmodule

// File: tb/tb_instr_issue_ctrl.sv
// Directed bench for instr_issue_ctrl with a behavioural program memory of
// configurable read latency.
module tb_instr_issue_ctrl;

  logic        clk;
  logic        reset;
  logic        run;
  logic [9:0]  mem_addr;
  logic        mem_rd_en;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic [3:0]  opcode;
  logic [3:0]  rdest;
  logic [3:0]  rsrc;
  logic [15:0] immediate;
  logic        useImmediate;
  logic        issue_valid;
  logic        dp_ready;
  logic        halted;
  logic [9:0]  pc;
  logic [15:0] instr_count;

  logic [15:0] mem [0:1023];
  int unsigned lat;
  logic        inject_stray;
  int          n_tests;
  int          n_fail;
  logic        found;

  instr_issue_ctrl #(
    .ADDR_W    (10),
    .START_ADDR(10'd0),
    .ZEXT_MASK (16'h0040),
    .HALT_OP   (4'hF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .mem_addr    (mem_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_rdata   (mem_rdata),
    .mem_rvalid  (mem_rvalid),
    .opcode      (opcode),
    .rdest       (rdest),
    .rsrc        (rsrc),
    .immediate   (immediate),
    .useImmediate(useImmediate),
    .issue_valid (issue_valid),
    .dp_ready    (dp_ready),
    .halted      (halted),
    .pc          (pc),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: a request seen at a falling edge is answered `lat`
  // falling edges later with a one-cycle rvalid pulse.
  initial begin
    logic [9:0] a;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (inject_stray) begin
        mem_rdata  = 16'h7777;
        mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
      end else if (mem_rd_en) begin
        a = mem_addr;
        repeat (lat) @(negedge clk);
        mem_rdata  = mem[a];
        mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    lat          = 1;
    inject_stray = 1'b0;
    found        = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0123;
    mem[0] = 16'h0351;
    mem[1] = 16'h52F0;
    mem[2] = 16'hF000;
    mem[3] = 16'h1A80;

    reset    = 1'b1;
    run      = 1'b0;
    dp_ready = 1'b1;
    repeat (3) tick();
    chk("rst_valid", issue_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_pc", pc, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_imm", immediate, 0);
    reset = 1'b0;
    tick();
    chk("idle_no_fetch", mem_rd_en, 0);

    // instruction 0: register form, minimum 3-cycle latency
    run = 1'b1;
    tick();
    chk("i0_rd_en", mem_rd_en, 1);
    chk("i0_addr", mem_addr, 0);
    tick();
    chk("i0_wait_rd_en", mem_rd_en, 0);
    chk("i0_wait_valid", issue_valid, 0);
    tick();
    chk("i0_valid", issue_valid, 1);
    chk("i0_opcode", opcode, 5);
    chk("i0_rdest", rdest, 3);
    chk("i0_rsrc", rsrc, 1);
    chk("i0_useimm", useImmediate, 0);
    chk("i0_imm", immediate, 0);
    tick();
    chk("i0_done_valid", issue_valid, 0);
    chk("i0_pc", pc, 1);
    chk("i0_count", instr_count, 1);
    chk("i1_rd_en", mem_rd_en, 1);
    chk("i1_addr", mem_addr, 1);

    // instruction 1: immediate form sign-extended, back-pressure, stray rvalid
    dp_ready = 1'b0;
    tick();
    tick();
    chk("i1_valid", issue_valid, 1);
    chk("i1_opcode", opcode, 5);
    chk("i1_rdest", rdest, 2);
    chk("i1_rsrc", rsrc, 0);
    chk("i1_useimm", useImmediate, 1);
    chk("i1_imm", immediate, 16'hFFF0);
    inject_stray = 1'b1;
    tick();
    inject_stray = 1'b0;
    chk("hold1_valid", issue_valid, 1);
    chk("hold1_imm", immediate, 16'hFFF0);
    chk("hold1_opcode", opcode, 5);
    chk("hold1_pc", pc, 1);
    tick();
    chk("hold2_valid", issue_valid, 1);
    chk("hold2_imm", immediate, 16'hFFF0);
    chk("hold2_count", instr_count, 1);
    tick();
    chk("hold3_valid", issue_valid, 1);
    chk("hold3_rdest", rdest, 2);
    chk("hold3_pc", pc, 1);
    dp_ready = 1'b1;
    tick();
    chk("i1_pc", pc, 2);
    chk("i1_count", instr_count, 2);
    chk("i2_rd_en", mem_rd_en, 1);

    // instruction 2: HALT
    tick();
    tick();
    chk("halt_halted", halted, 1);
    chk("halt_valid", issue_valid, 0);
    chk("halt_pc", pc, 2);
    tick();
    chk("halt_stay", halted, 1);
    chk("halt_no_fetch", mem_rd_en, 0);
    chk("halt_count", instr_count, 2);
    run = 1'b0;
    tick();
    chk("halt_to_idle", halted, 0);
    run = 1'b1;
    tick();
    chk("refetch_rd_en", mem_rd_en, 1);
    chk("refetch_addr", mem_addr, 2);
    tick();
    tick();
    chk("rehalt", halted, 1);
    run = 1'b0;
    tick();
    chk("rehalt_idle", halted, 0);

    // address 2 replaced by a zero-extended immediate, 4-cycle memory
    mem[2] = 16'h62F0;
    lat    = 4;
    run    = 1'b1;
    tick();
    chk("lat4_addr", mem_addr, 2);
    tick();
    tick();
    tick();
    tick();
    chk("lat4_not_yet", issue_valid, 0);
    tick();
    chk("lat4_valid", issue_valid, 1);
    chk("zext_opcode", opcode, 6);
    chk("zext_imm", immediate, 16'h00F0);
    chk("zext_useimm", useImmediate, 1);
    lat = 1;
    tick();
    chk("i2b_pc", pc, 3);
    chk("i2b_count", instr_count, 3);

    // run drops during FETCH: instruction 3 still completes, then IDLE
    run = 1'b0;
    tick();
    tick();
    chk("i3_valid", issue_valid, 1);
    chk("i3_opcode", opcode, 1);
    chk("i3_rdest", rdest, 4'hA);
    chk("i3_imm", immediate, 16'hFF80);
    tick();
    chk("i3_done_valid", issue_valid, 0);
    chk("i3_idle_rd_en", mem_rd_en, 0);
    chk("i3_pc", pc, 4);
    chk("i3_count", instr_count, 4);
    tick();
    chk("idle_stays", mem_rd_en, 0);
    chk("idle_pc", pc, 4);

    // run through to the top of the address space
    run = 1'b1;
    for (int i = 0; i < 4000 && !found; i++) begin
      tick();
      if (pc == 10'd1023 && issue_valid) found = 1'b1;
    end
    chk("wrap_reached", found, 1);
    chk("wrap_count_pre", instr_count, 1023);
    tick();
    chk("wrap_pc", pc, 0);
    chk("wrap_count", instr_count, 1024);
    chk("wrap_fetch_addr", mem_addr, 0);

    // reset during ISSUE
    dp_ready = 1'b0;
    tick();
    tick();
    chk("pre_rst_valid", issue_valid, 1);
    reset = 1'b1;
    run   = 1'b0;
    tick();
    chk("mid_rst_valid", issue_valid, 0);
    chk("mid_rst_pc", pc, 0);
    chk("mid_rst_count", instr_count, 0);
    chk("mid_rst_opcode", opcode, 0);
    chk("mid_rst_rdest", rdest, 0);
    chk("mid_rst_rsrc", rsrc, 0);
    chk("mid_rst_imm", immediate, 0);
    chk("mid_rst_useimm", useImmediate, 0);
    chk("mid_rst_halted", halted, 0);
    chk("mid_rst_rd_en", mem_rd_en, 0);
    reset = 1'b0;
    tick();
    chk("post_rst_idle", mem_rd_en, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
